// File: rtl/ghost_wall_collision_gen.sv
// Per-frame ghost/wall collision source: counts overlap pixels during the scan,
// fires one collision pulse per frame with the edge class of the first overlap.
module ghost_wall_collision_gen #(
  parameter int unsigned MIN_OVERLAP = 4,
  parameter int unsigned EDGE_BAND   = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       ghostDrawingRequest,
  input  logic       wallDrawingRequest,
  input  logic [4:0] offsetX,
  input  logic [4:0] offsetY,
  output logic       collision,
  output logic [2:0] HitEdgeCode,
  output logic [1:0] rnd_dir
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   MIN_OV  = (CNT_W+1)'(MIN_OVERLAP);
  localparam logic [4:0]       BAND_LO = 5'(EDGE_BAND);
  localparam logic [4:0]       BAND_HI = 5'(31 - EDGE_BAND);

  typedef enum logic [1:0] {WAIT_ST, SCAN_ST, FIRED_ST} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] ov_cnt;
  logic [2:0]       pend_code;

  logic             ov_c;
  logic [2:0]       edge_cls_c;
  logic             hit_now_c;
  logic             lfsr_fb_c;

  assign ov_c      = ghostDrawingRequest & wallDrawingRequest;
  assign hit_now_c = (({1'b0, ov_cnt} + (CNT_W+1)'(1)) == MIN_OV);
  assign lfsr_fb_c = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Edge class of the current ghost pixel; vertical edges take priority.
  always_comb begin
    edge_cls_c = 3'd5;
    if (offsetY < BAND_LO)      edge_cls_c = 3'd1;
    else if (offsetY > BAND_HI) edge_cls_c = 3'd3;
    else if (offsetX < BAND_LO) edge_cls_c = 3'd4;
    else if (offsetX > BAND_HI) edge_cls_c = 3'd2;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= WAIT_ST;
      lfsr        <= LFSR_SEED;
      ov_cnt      <= '0;
      pend_code   <= 3'd0;
      collision   <= 1'b0;
      HitEdgeCode <= 3'd0;
      rnd_dir     <= 2'd0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb_c};
      collision <= 1'b0;
      // Frame start overrides any overlap or pending hit in the same cycle.
      if (startOfFrame) begin
        ov_cnt    <= '0;
        pend_code <= 3'd0;
        rnd_dir   <= lfsr[1:0];
        state     <= SCAN_ST;
      end else begin
        case (state)
          SCAN_ST: begin
            if (ov_c) begin
              if (ov_cnt != CNT_MAX) ov_cnt <= ov_cnt + CNT_W'(1);
              if (ov_cnt == '0) pend_code <= edge_cls_c;
              if (hit_now_c) begin
                collision   <= 1'b1;
                HitEdgeCode <= (ov_cnt == '0) ? edge_cls_c : pend_code;
                state       <= FIRED_ST;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghost_wall_collision_gen.sv
// Scoreboard bench for ghost_wall_collision_gen: directed frames push expected
// pulses; a forked monitor pops and checks them as the DUT fires.
module tb_ghost_wall_collision_gen;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, gdr, wdr;
  logic [4:0] ox, oy;
  logic       collision;
  logic [2:0] HitEdgeCode;
  logic [1:0] rnd_dir;

  ghost_wall_collision_gen #(
    .MIN_OVERLAP(4),
    .EDGE_BAND(6),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(sof),
    .ghostDrawingRequest(gdr),
    .wallDrawingRequest(wdr),
    .offsetX(ox),
    .offsetY(oy),
    .collision(collision),
    .HitEdgeCode(HitEdgeCode),
    .rnd_dir(rnd_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR (taps 16,14,13,11) and frame-sampled direction.
  logic [15:0] m_lfsr;
  logic [1:0]  m_rnd;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_lfsr <= 16'hACE1;
      m_rnd  <= 2'd0;
    end else begin
      if (sof) m_rnd <= m_lfsr[1:0];
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [2:0] held;
    exp_t       e;
    held = 3'd0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        held = 3'd0;
      end else begin
        if (collision !== 1'b0) begin
          if (sb.size() == 0) begin
            chk("unexpected_collision", 32'(collision), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("collision_cycle", 32'(cyc), 32'(e.cyc));
            held = e.code;
          end
        end
        chk("hit_edge_code", 32'(HitEdgeCode), 32'(held));
        chk("rnd_dir", 32'(rnd_dir), 32'(m_rnd));
      end
    end
  endtask

  task automatic drive(input logic s, input logic g, input logic w, input int x, input int y);
    @(negedge clk);
    sof = s; gdr = g; wdr = w; ox = 5'(x); oy = 5'(y);
  endtask

  task automatic ovl(input int x, input int y, input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b1, x, y);
  endtask

  task automatic hit(input int x, input int y, input logic [2:0] code);
    exp_t e;
    drive(1'b0, 1'b1, 1'b1, x, y);
    e.cyc  = cyc + 1;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic frame();
    drive(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    resetN = 1'b0;
    sof = 1'b0; gdr = 1'b0; wdr = 1'b0; ox = 5'd0; oy = 5'd0;
    fork monitor(); join_none

    // Reset values and first LFSR steps from the seed.
    idle(2);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_code", 32'(HitEdgeCode), 32'd0);
    chk("rst_rnd_dir", 32'(rnd_dir), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
    resetN = 1'b1;
    idle(1);
    chk("lfsr_step1", 32'(dut.lfsr), 32'h000059C3);
    idle(1);
    chk("lfsr_step2", 32'(dut.lfsr), 32'h0000B387);

    // Overlaps before any frame start are ignored.
    ovl(15, 2, 6);
    idle(2);

    // Top edge; non-overlap cycles in between are not counted; one pulse only.
    frame();
    ovl(15, 2, 2);
    drive(1'b0, 1'b1, 1'b0, 15, 2);
    drive(1'b0, 1'b0, 1'b1, 15, 2);
    ovl(15, 2, 1);
    hit(15, 2, 3'd1);
    ovl(15, 2, 6);
    idle(3);

    // Short frame discarded; next frame needs its own four (bottom edge).
    frame();
    ovl(15, 15, 3);
    idle(2);
    frame();
    ovl(15, 28, 3);
    hit(15, 28, 3'd3);
    idle(2);

    // Edge class comes from the first overlap of the frame.
    frame();
    ovl(0, 15, 1);
    ovl(31, 15, 2);
    hit(31, 15, 3'd4);
    idle(2);
    frame();
    ovl(15, 15, 3);
    hit(15, 15, 3'd5);
    idle(2);
    frame();
    ovl(26, 25, 1);
    ovl(5, 6, 2);
    hit(5, 6, 3'd2);
    idle(2);
    frame();
    ovl(0, 26, 3);
    hit(0, 26, 3'd3);
    idle(2);

    // Frame start on the would-be 4th overlap: no pulse, overlap not counted.
    frame();
    ovl(15, 15, 3);
    drive(1'b1, 1'b1, 1'b1, 15, 2);
    ovl(31, 15, 3);
    hit(31, 15, 3'd2);
    idle(2);

    // Long overlap run after the pulse still gives one pulse.
    frame();
    ovl(15, 15, 3);
    hit(15, 15, 3'd5);
    ovl(15, 15, 1100);
    idle(2);
    chk("lfsr_model", 32'(dut.lfsr), 32'(m_lfsr));

    // Reset mid-scan with three overlaps counted.
    frame();
    ovl(15, 2, 3);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_collision", 32'(collision), 32'd0);
    chk("midrst_code", 32'(HitEdgeCode), 32'd0);
    chk("midrst_rnd_dir", 32'(rnd_dir), 32'd0);
    chk("midrst_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
    idle(2);
    resetN = 1'b1;
    ovl(15, 2, 6);
    idle(2);
    frame();
    ovl(15, 15, 3);
    hit(15, 15, 3'd5);
    idle(4);
    chk("lfsr_model_end", 32'(dut.lfsr), 32'(m_lfsr));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ghost_wall_collision_gen.md
# ghost_wall_collision_gen

Per-frame collision source for one ghost: watches the ghost and maze-wall drawing requests during the raster scan and emits a single-cycle `collision` pulse, a `HitEdgeCode`, and a frame-stable random direction `rnd_dir`. These are exactly the inputs the ghost movement controller consumes. One instance sits between the ghost/wall drawing units and one ghost mover. It is clocked by the VGA pixel clock.

## Interface
- `MIN_OVERLAP`, default 4: number of overlapping pixels in one frame needed to declare a hit. Valid range 1..1023.
- `EDGE_BAND`, default 6: width in pixels of the edge band inside the 32x32 ghost bitmap.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk` in 1: pixel clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse at the start of each frame.
- `ghostDrawingRequest` in 1: ghost pixel is opaque at the current pixel.
- `wallDrawingRequest` in 1: wall pixel is present at the current pixel.
- `offsetX` in 5: ghost-relative X of the current pixel. Valid only when `ghostDrawingRequest` is 1.
- `offsetY` in 5: ghost-relative Y of the current pixel. Valid only when `ghostDrawingRequest` is 1.
- `collision` out 1: one-cycle hit pulse, at most one per frame.
- `HitEdgeCode` out 3: which part of the ghost made the hit. Held until the next pulse.
- `rnd_dir` out 2: random direction. Constant for a whole frame.

## Operation
- Overlap: `ov = ghostDrawingRequest & wallDrawingRequest`, evaluated combinationally on the current inputs.
- State machine `{WAIT_ST, SCAN_ST, FIRED_ST}`, reset to `WAIT_ST`:
  - `WAIT_ST`: ignores `ov`. Goes to `SCAN_ST` on `startOfFrame`.
  - `SCAN_ST`: each cycle with `ov`=1, `ovCnt` (10 bits) increments. On the first counted overlap of the frame, the edge class of that pixel is captured into `pendCode`. On the cycle where `ovCnt+1 == MIN_OVERLAP`, the block drives `collision`, loads `HitEdgeCode <= pendCode`, and goes to `FIRED_ST`.
  - `FIRED_ST`: ignores `ov`. Goes to `SCAN_ST` on `startOfFrame`.
- Any state, on `startOfFrame`: `ovCnt <= 0`, `pendCode <= 0`, `rnd_dir <= lfsr[1:0]`, next state `SCAN_ST`.
- Edge class of a pixel, in priority order:
  - `offsetY < EDGE_BAND` → 3'd1 (top).
  - `offsetY > 31-EDGE_BAND` → 3'd3 (bottom).
  - `offsetX < EDGE_BAND` → 3'd4 (left).
  - `offsetX > 31-EDGE_BAND` → 3'd2 (right).
  - Otherwise → 3'd5 (interior).
  - 3'd0 means no hit yet.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left every clock.
  - Never reaches zero from a nonzero seed.
  - `rnd_dir` samples it only at `startOfFrame`.
- `ovCnt` saturates at 1023. The pulse fires exactly once per frame, even when more than 1023 pixels overlap.

## Timing
- Reset values: `collision`=0, `HitEdgeCode`=0, `rnd_dir`=0, `lfsr`=`LFSR_SEED`, `ovCnt`=0, `pendCode`=0, state `WAIT_ST`.
- Collision latency: `collision` is registered. It is high for exactly one cycle, the cycle after the clock edge that sampled the `MIN_OVERLAP`-th overlap.
- `HitEdgeCode` changes on the same edge that raises `collision`, and is stable from that edge onward.
- `rnd_dir` changes only on the edge after `startOfFrame`. It is therefore stable while `collision` is high.
- `startOfFrame` and `ov` in the same cycle: `startOfFrame` wins. The counter clears and that `ov` is not counted.
- `startOfFrame` in the same cycle that would produce the pulse: no pulse is issued; the frame restarts.
- Frame ends before `MIN_OVERLAP` is reached: no pulse. The partial count and `pendCode` are discarded at `startOfFrame`.
- Reset asserted mid-frame: all registers take reset values immediately. After release, nothing is counted until the next `startOfFrame`.
- `MIN_OVERLAP`=1: the pulse follows the first overlap by one cycle, and `HitEdgeCode` equals that pixel's class.

## Test plan
- Reset, then a frame with 10 overlap cycles at offset (15,2), `MIN_OVERLAP`=4 → one `collision` pulse, the cycle after the 4th overlap; `HitEdgeCode`=1. No second pulse that frame.
- Frame with 3 overlaps → no pulse. Next frame with 4 overlaps → pulse. Confirms the count clears at `startOfFrame`.
- First overlap at (0,15), later overlaps at (31,15) → `HitEdgeCode`=4 (left). Interior first pixel (15,15) → 5.
- `startOfFrame` coincident with the 4th overlap → no pulse. The following frame then needs a fresh 4 overlaps.
- Check LFSR after reset: after N clocks the `lfsr` value matches a reference model starting from 16'hACE1. `rnd_dir` equals `lfsr[1:0]` as sampled at the `startOfFrame` edge, and does not change between frame pulses.
- Assert `resetN` low mid-scan with `ovCnt`=3 → all outputs go to 0 at once. After release, overlaps before the next `startOfFrame` produce no pulse.
